// File: rtl/sensor_cmd_if.sv
// Signal bundle between the command sequencer and its neighbours
// (uart_rx, uart_tx and the DHT sensor reader).
//
// Handshake semantics: every *_done, tx_start and sensor_req line is a
// single-cycle strobe, and the data that goes with it is valid in that same
// cycle. rx_byte goes with rx_done. sensor_error, sensor_hum and sensor_temp
// go with sensor_done. tx_byte is presented with tx_start and stays stable
// until tx_done. tx_active is a level that means "uart_tx cannot accept a
// start".
interface sensor_cmd_if;
    logic       rx_done;
    logic [7:0] rx_byte;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       sensor_req;
    logic [4:0] sensor_addr;
    logic       sensor_done;
    logic       sensor_error;
    logic [7:0] sensor_hum;
    logic [7:0] sensor_temp;
    logic       busy;

    modport master (
        input  rx_done, rx_byte, tx_active, tx_done,
               sensor_done, sensor_error, sensor_hum, sensor_temp,
        output tx_start, tx_byte, sensor_req, sensor_addr, busy
    );

    modport slave (
        output rx_done, rx_byte, tx_active, tx_done,
               sensor_done, sensor_error, sensor_hum, sensor_temp,
        input  tx_start, tx_byte, sensor_req, sensor_addr, busy
    );
endinterface

// File: rtl/sensor_cmd_controller.sv
// Command sequencer. It takes 2-byte (command, address) requests from uart_rx,
// runs a sensor read when the command needs one, and sends a 2-byte
// (code, data) reply through uart_tx. It can also send periodic reports
// while continuous mode is on.
module sensor_cmd_controller #(
    parameter int NUM_SENSORS    = 1,
    parameter int BYTE_TIMEOUT   = 50_000_000,
    parameter int SENSOR_TIMEOUT = 100_000_000,
    parameter int CONT_PERIOD    = 100_000_000
) (
    input  logic         clock,
    input  logic         reset_n,
    sensor_cmd_if.master bus,
    output logic [3:0]   dbg_state
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        WAIT_ADDR  = 4'd1,
        DECODE     = 4'd2,
        SENSE_REQ  = 4'd3,
        SENSE_WAIT = 4'd4,
        SEND_CODE  = 4'd5,
        WAIT_CODE  = 4'd6,
        SEND_DATA  = 4'd7,
        WAIT_DATA  = 4'd8
    } state_t;

    // Last counter value before each timeout or period wrap fires
    localparam logic [31:0] BYTE_LAST   = 32'(BYTE_TIMEOUT - 1);
    localparam logic [31:0] SENSOR_LAST = 32'(SENSOR_TIMEOUT - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(CONT_PERIOD - 1);

    state_t      state;
    logic [7:0]  cmd_q;
    logic [7:0]  addr_q;
    logic [7:0]  code_q;
    logic [7:0]  data_q;
    logic [31:0] tmo_cnt;
    logic [31:0] per_cnt;
    logic        cont_on;
    logic        cont_hum;
    logic [4:0]  cont_addr;
    logic        pending;
    logic        tick;
    logic        req_bad;

    assign tick      = cont_on && (per_cnt == PERIOD_LAST);
    assign req_bad   = (cmd_q > 8'h05) || (addr_q >= 8'(NUM_SENSORS));
    assign bus.busy  = (state != IDLE);
    assign dbg_state = state;

    // Request sequencer, period counter and registered strobe outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            bus.tx_start    <= 1'b0;
            bus.tx_byte     <= 8'h00;
            bus.sensor_req  <= 1'b0;
            bus.sensor_addr <= 5'd0;
            cmd_q           <= 8'h00;
            addr_q          <= 8'h00;
            code_q          <= 8'h00;
            data_q          <= 8'h00;
            tmo_cnt         <= 32'd0;
            per_cnt         <= 32'd0;
            cont_on         <= 1'b0;
            cont_hum        <= 1'b0;
            cont_addr       <= 5'd0;
            pending         <= 1'b0;
        end else begin
            bus.tx_start   <= 1'b0;
            bus.sensor_req <= 1'b0;

            // The period counter runs whatever the FSM is doing.
            // Ticks that arrive while busy merge into the one pending flag.
            if (cont_on) begin
                if (tick) begin
                    per_cnt <= 32'd0;
                    pending <= 1'b1;
                end else begin
                    per_cnt <= per_cnt + 32'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.rx_done) begin
                        // A host request beats a pending report.
                        // The report stays pending until the host request is served.
                        cmd_q   <= bus.rx_byte;
                        tmo_cnt <= 32'd0;
                        state   <= WAIT_ADDR;
                    end else if (pending) begin
                        // A tick in this same cycle keeps the flag set.
                        pending         <= tick;
                        cmd_q           <= cont_hum ? 8'h02 : 8'h01;
                        addr_q          <= {3'b000, cont_addr};
                        bus.sensor_addr <= cont_addr;
                        bus.sensor_req  <= 1'b1;
                        state           <= SENSE_REQ;
                    end
                end
                WAIT_ADDR: begin
                    if (bus.rx_done) begin
                        addr_q <= bus.rx_byte;
                        state  <= DECODE;
                    end else if (tmo_cnt == BYTE_LAST) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    data_q <= 8'h00;
                    if (req_bad) begin
                        code_q <= 8'hFF;
                        state  <= SEND_CODE;
                    end else begin
                        case (cmd_q)
                            8'h03, 8'h04: begin
                                cont_on   <= 1'b1;
                                cont_hum  <= (cmd_q == 8'h04);
                                cont_addr <= addr_q[4:0];
                                per_cnt   <= 32'd0;
                                pending   <= 1'b0;
                                code_q    <= (cmd_q == 8'h04) ? 8'h0B : 8'h0A;
                                state     <= SEND_CODE;
                            end
                            8'h05: begin
                                cont_on <= 1'b0;
                                per_cnt <= 32'd0;
                                pending <= 1'b0;
                                code_q  <= 8'h0C;
                                state   <= SEND_CODE;
                            end
                            default: begin
                                bus.sensor_addr <= addr_q[4:0];
                                bus.sensor_req  <= 1'b1;
                                state           <= SENSE_REQ;
                            end
                        endcase
                    end
                end
                SENSE_REQ: begin
                    tmo_cnt <= 32'd0;
                    state   <= SENSE_WAIT;
                end
                SENSE_WAIT: begin
                    if (bus.sensor_done) begin
                        state <= SEND_CODE;
                        if (bus.sensor_error) begin
                            code_q <= 8'h1F;
                            data_q <= 8'h00;
                        end else begin
                            case (cmd_q)
                                8'h01: begin
                                    code_q <= 8'h01;
                                    data_q <= bus.sensor_temp;
                                end
                                8'h02: begin
                                    code_q <= 8'h02;
                                    data_q <= bus.sensor_hum;
                                end
                                default: begin
                                    code_q <= 8'h07;
                                    data_q <= 8'h00;
                                end
                            endcase
                        end
                    end else if (tmo_cnt == SENSOR_LAST) begin
                        code_q <= 8'h1F;
                        data_q <= 8'h00;
                        state  <= SEND_CODE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                SEND_CODE: begin
                    if (!bus.tx_active) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_byte  <= code_q;
                        state        <= WAIT_CODE;
                    end
                end
                WAIT_CODE: begin
                    if (bus.tx_done) begin
                        state <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (!bus.tx_active) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_byte  <= data_q;
                        state        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (bus.tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sensor_cmd_controller.sv
// Directed bench for sensor_cmd_controller. Reply bytes are queued when a
// request is issued, and a monitor pops and compares them on every tx_start.
module tb_sensor_cmd_controller;
    localparam int BYTE_TO = 200;
    localparam int SENS_TO = 300;
    localparam int PERIOD  = 1000;
    localparam logic [7:0] TEMP = 8'h19;
    localparam logic [7:0] HUM  = 8'h37;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] dbg_state;

    sensor_cmd_if bus();

    sensor_cmd_controller #(
        .NUM_SENSORS(1), .BYTE_TIMEOUT(BYTE_TO),
        .SENSOR_TIMEOUT(SENS_TO), .CONT_PERIOD(PERIOD)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int tx_cnt   = 0;
    int sreq_cnt = 0;
    int sreq_cyc = 0;
    int sens_mode = 0;  // 0 good read, 1 error flag, 2 never answers
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every tx_start must carry the next expected byte
    initial forever begin
        @(negedge clock);
        if (reset_n && bus.tx_start) begin
            tx_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tx: got 0x%0h expected no byte", bus.tx_byte);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("tx_byte", 32'(bus.tx_byte), 32'(e));
            end
        end
    end

    // uart_tx model: busy for a few cycles, then tx_done
    initial begin
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && bus.tx_start) begin
                bus.tx_active = 1'b1;
                repeat (4) @(negedge clock);
                bus.tx_active = 1'b0;
                bus.tx_done   = 1'b1;
                @(negedge clock);
                bus.tx_done = 1'b0;
            end
        end
    end

    // Sensor model: answers sensor_req according to sens_mode
    initial begin
        bus.sensor_done  = 1'b0;
        bus.sensor_error = 1'b0;
        bus.sensor_temp  = TEMP;
        bus.sensor_hum   = HUM;
        forever begin
            @(negedge clock);
            if (reset_n && bus.sensor_req) begin
                sreq_cnt++;
                sreq_cyc = cyc;
                if (sens_mode != 2) begin
                    repeat (3) @(negedge clock);
                    bus.sensor_error = (sens_mode == 1);
                    bus.sensor_done  = 1'b1;
                    @(negedge clock);
                    bus.sensor_done  = 1'b0;
                    bus.sensor_error = 1'b0;
                end
            end
        end
    end

    // Driver: one rx_done strobe with its byte
    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        bus.rx_byte = b;
        bus.rx_done = 1'b1;
        @(negedge clock);
        bus.rx_done = 1'b0;
    endtask

    task automatic expect_reply(input logic [7:0] code, input logic [7:0] data);
        exp_q.push_back(code);
        exp_q.push_back(data);
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic request(input string name, input logic [7:0] c, input logic [7:0] a,
                           input logic [7:0] code, input logic [7:0] data, input int budget);
        expect_reply(code, data);
        send_byte(c);
        send_byte(a);
        wait_idle(name, budget);
    endtask

    // Directed scenario sequence and final report
    initial begin
        int s0, t0, r1, r2;
        logic hit;
        bus.rx_done = 1'b0;
        bus.rx_byte = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_sensor_req", 32'(bus.sensor_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
        check("rst_sensor_addr", 32'(bus.sensor_addr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Temperature read, with sensor_req latency checked after the address byte
        s0 = sreq_cnt;
        expect_reply(8'h01, TEMP);
        send_byte(8'h01);
        send_byte(8'h00);
        check("lat_decode_no_req", 32'(bus.sensor_req), 32'd0);
        @(negedge clock);
        check("lat_req_2_cycles", 32'(bus.sensor_req), 32'd1);
        check("lat_sensor_addr", 32'(bus.sensor_addr), 32'd0);
        wait_idle("temp_done", 100);
        check("temp_one_req", 32'(sreq_cnt - s0), 32'd1);

        request("hum_done", 8'h02, 8'h00, 8'h02, HUM, 100);
        request("status_done", 8'h00, 8'h00, 8'h07, 8'h00, 100);

        // Invalid command and invalid address must not start a read
        s0 = sreq_cnt;
        request("bad_cmd_done", 8'h09, 8'h00, 8'hFF, 8'h00, 100);
        request("bad_addr_done", 8'h02, 8'h05, 8'hFF, 8'h00, 100);
        request("cmd06_done", 8'h06, 8'h00, 8'hFF, 8'h00, 100);
        request("addr1_done", 8'h00, 8'h01, 8'hFF, 8'h00, 100);
        check("bad_no_req", 32'(sreq_cnt - s0), 32'd0);

        // Sensor error flag, then a sensor that never answers
        sens_mode = 1;
        request("err_done", 8'h02, 8'h00, 8'h1F, 8'h00, 100);
        sens_mode = 2;
        request("sens_tmo_done", 8'h01, 8'h00, 8'h1F, 8'h00, SENS_TO + 100);
        sens_mode = 0;

        // Lone command byte times out silently, then service continues
        t0 = tx_cnt;
        send_byte(8'h01);
        repeat (BYTE_TO - 5) @(negedge clock);
        check("byte_tmo_still_busy", 32'(bus.busy), 32'd1);
        repeat (10) @(negedge clock);
        check("byte_tmo_idle", 32'(bus.busy), 32'd0);
        check("byte_tmo_no_tx", 32'(tx_cnt - t0), 32'd0);
        request("after_tmo_done", 8'h00, 8'h00, 8'h07, 8'h00, 100);

        // Continuous temperature: ack, then one report per period
        request("cont_on_done", 8'h03, 8'h00, 8'h0A, 8'h00, 100);
        expect_reply(8'h01, TEMP);
        wait_idle("report1_done", PERIOD + 100);
        r1 = sreq_cyc;
        expect_reply(8'h01, TEMP);
        wait_idle("report2_done", PERIOD + 100);
        r2 = sreq_cyc;
        check("report_interval", 32'(r2 - r1), 32'(PERIOD));

        // Host request lands in the very IDLE cycle that sees the new pending report
        hit = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (cyc == r2 + PERIOD - 2) begin
                hit = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("collide_aligned", 32'(hit), 32'd1);
        s0 = sreq_cnt;
        expect_reply(8'h07, 8'h00);
        expect_reply(8'h01, TEMP);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle("collide_done", 400);
        check("collide_two_reads", 32'(sreq_cnt - s0), 32'd2);

        // Continuous off: ack, then silence for two periods
        request("cont_off_done", 8'h05, 8'h00, 8'h0C, 8'h00, 100);
        t0 = tx_cnt;
        s0 = sreq_cnt;
        repeat (2 * PERIOD + 100) @(negedge clock);
        check("off_no_tx", 32'(tx_cnt - t0), 32'd0);
        check("off_no_req", 32'(sreq_cnt - s0), 32'd0);

        // Reset during WAIT_CODE aborts at once and clears continuous mode
        request("cont_hum_done", 8'h04, 8'h00, 8'h0B, 8'h00, 100);
        exp_q.push_back(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (dbg_state == 4'd6) begin
                hit = 1'b1;
                break;
            end
        end
        check("reached_wait_code", 32'(hit), 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_tx_start", 32'(bus.tx_start), 32'd0);
        check("arst_sensor_req", 32'(bus.sensor_req), 32'd0);
        check("arst_tx_byte", 32'(bus.tx_byte), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        t0 = tx_cnt;
        s0 = sreq_cnt;
        repeat (2 * PERIOD + 100) @(negedge clock);
        check("arst_no_tx", 32'(tx_cnt - t0), 32'd0);
        check("arst_mode_off", 32'(sreq_cnt - s0), 32'd0);
        check("arst_idle", 32'(bus.busy), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
